// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared types and constants for the control-side hazard pipeline.
// Holds the stage record carried from ID/EX down to MEM/WB.
package pipe_hazard_tracker_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 5;

    localparam logic [OP_W-1:0] NOP_OP = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE = 6'b000101;
    localparam logic [OP_W-1:0] OP_J   = 6'b000010;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic             wreg;
        logic             reg2reg;
        logic             wmem;
        logic             valid;
    } stage_t;

    // A bubble opcode must never look like a control transfer to the decode unit.
    function automatic logic is_ctrl_op(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
    endfunction

endpackage

// File: rtl/pipe_hazard_tracker_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Latency: count reflects inc one edge later; no backpressure.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// ID/EX, EX/MEM, MEM/WB control registers feeding the decode hazard logic, plus perf counters.
// Latency: ID fields reach e/m/w outputs 1/2/3 edges later; STALL/Condep only insert bubbles.
module pipe_hazard_tracker #(
    parameter int                       CNT_W  = 16,
    parameter logic [5:0]               NOP_OP = pipe_hazard_tracker_pkg::NOP_OP
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [5:0]       Op,
    input  logic [4:0]       Rt,
    input  logic [4:0]       Rd,
    input  logic             Regrt,
    input  logic             Wreg,
    input  logic             Reg2reg,
    input  logic             Wmem,
    input  logic             STALL,
    input  logic             Condep,
    output logic [5:0]       eOp,
    output logic [4:0]       eRd,
    output logic             eWreg,
    output logic             eReg2reg,
    output logic             eWmem,
    output logic [4:0]       mRd,
    output logic             mWreg,
    output logic             mReg2reg,
    output logic             mWmem,
    output logic [4:0]       wRd,
    output logic             wWreg,
    output logic             wReg2reg,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    import pipe_hazard_tracker_pkg::*;

    // A misconfigured branch/jump bubble opcode falls back to the safe default.
    localparam logic [OP_W-1:0] BUBBLE_OP =
        is_ctrl_op(NOP_OP) ? pipe_hazard_tracker_pkg::NOP_OP : NOP_OP;

    stage_t           e_q;
    stage_t           m_q;
    stage_t           w_q;
    logic [REG_W-1:0] d_rd;
    logic             bubble;
    logic             stall_inc;
    logic             flush_inc;
    logic             unused_wb_bits;

    assign d_rd      = Regrt ? Rt : Rd;
    assign bubble    = !STALL || !Condep;
    assign stall_inc = !STALL && Condep;
    assign flush_inc = !Condep;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            e_q <= '{op: BUBBLE_OP, rd: '0, wreg: 1'b0, reg2reg: 1'b0, wmem: 1'b0, valid: 1'b0};
            m_q <= '{op: BUBBLE_OP, rd: '0, wreg: 1'b0, reg2reg: 1'b0, wmem: 1'b0, valid: 1'b0};
            w_q <= '{op: BUBBLE_OP, rd: '0, wreg: 1'b0, reg2reg: 1'b0, wmem: 1'b0, valid: 1'b0};
        end else begin
            if (bubble) begin
                e_q <= '{op: BUBBLE_OP, rd: '0, wreg: 1'b0, reg2reg: 1'b1, wmem: 1'b0, valid: 1'b0};
            end else begin
                e_q <= '{op: Op, rd: d_rd, wreg: Wreg, reg2reg: Reg2reg, wmem: Wmem, valid: 1'b1};
            end
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    assign eOp      = e_q.op;
    assign eRd      = e_q.rd;
    assign eWreg    = e_q.wreg;
    assign eReg2reg = e_q.reg2reg;
    assign eWmem    = e_q.wmem;
    assign mRd      = m_q.rd;
    assign mWreg    = m_q.wreg;
    assign mReg2reg = m_q.reg2reg;
    assign mWmem    = m_q.wmem;
    assign wRd      = w_q.rd;
    assign wWreg    = w_q.wreg;
    assign wReg2reg = w_q.reg2reg;

    // Opcode and store flag have no consumer once past MEM.
    assign unused_wb_bits = ^{w_q.op, w_q.wmem};

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Clrn  (Clrn),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Clrn  (Clrn),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .Clk   (Clk),
        .Clrn  (Clrn),
        .inc   (w_q.valid),
        .count (retire_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Bench for pipe_hazard_tracker: directed scenarios plus randomized traffic against a queue model.
// A second instance with 4-bit counters exercises saturation.
module tb_pipe_hazard_tracker;

    logic       Clk = 1'b0;
    logic       Clrn = 1'b0;
    logic [5:0] Op = '0;
    logic [4:0] Rt = '0, Rd = '0;
    logic       Regrt = 1'b0, Wreg = 1'b0, Reg2reg = 1'b0, Wmem = 1'b0;
    logic       STALL = 1'b1, Condep = 1'b1;

    logic [5:0]  eOp, s_eOp;
    logic [4:0]  eRd, mRd, wRd, s_eRd, s_mRd, s_wRd;
    logic        eWreg, eReg2reg, eWmem, mWreg, mReg2reg, mWmem, wWreg, wReg2reg;
    logic        s_eWreg, s_eReg2reg, s_eWmem, s_mWreg, s_mReg2reg, s_mWmem, s_wWreg, s_wReg2reg;
    logic [15:0] stall_cnt, flush_cnt, retire_cnt;
    logic [3:0]  s_stall_cnt, s_flush_cnt, s_retire_cnt;

    always #5 Clk = ~Clk;

    pipe_hazard_tracker dut (
        .Clk(Clk), .Clrn(Clrn), .Op(Op), .Rt(Rt), .Rd(Rd), .Regrt(Regrt), .Wreg(Wreg),
        .Reg2reg(Reg2reg), .Wmem(Wmem), .STALL(STALL), .Condep(Condep),
        .eOp(eOp), .eRd(eRd), .eWreg(eWreg), .eReg2reg(eReg2reg), .eWmem(eWmem),
        .mRd(mRd), .mWreg(mWreg), .mReg2reg(mReg2reg), .mWmem(mWmem),
        .wRd(wRd), .wWreg(wWreg), .wReg2reg(wReg2reg),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    pipe_hazard_tracker #(.CNT_W(4)) dut_s (
        .Clk(Clk), .Clrn(Clrn), .Op(Op), .Rt(Rt), .Rd(Rd), .Regrt(Regrt), .Wreg(Wreg),
        .Reg2reg(Reg2reg), .Wmem(Wmem), .STALL(STALL), .Condep(Condep),
        .eOp(s_eOp), .eRd(s_eRd), .eWreg(s_eWreg), .eReg2reg(s_eReg2reg), .eWmem(s_eWmem),
        .mRd(s_mRd), .mWreg(s_mWreg), .mReg2reg(s_mReg2reg), .mWmem(s_mWmem),
        .wRd(s_wRd), .wWreg(s_wWreg), .wReg2reg(s_wReg2reg),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .retire_cnt(s_retire_cnt)
    );

    logic [28:0] act, s_act;
    assign act   = {eOp, eRd, eWreg, eReg2reg, eWmem, mRd, mWreg, mReg2reg, mWmem, wRd, wWreg, wReg2reg};
    assign s_act = {s_eOp, s_eRd, s_eWreg, s_eReg2reg, s_eWmem, s_mRd, s_mWreg, s_mReg2reg, s_mWmem,
                    s_wRd, s_wWreg, s_wReg2reg};

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rd;
        logic       wreg;
        logic       reg2reg;
        logic       wmem;
        logic       valid;
    } rec_t;

    // Model: pq[0..2] are the instructions currently in EX, MEM, WB.
    rec_t pq[$];
    int   m_stall, m_flush, m_retire;
    int   s_stall, s_flush, s_retire;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic int sat(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    function automatic logic [28:0] exp_vec();
        return {pq[0].op, pq[0].rd, pq[0].wreg, pq[0].reg2reg, pq[0].wmem,
                pq[1].rd, pq[1].wreg, pq[1].reg2reg, pq[1].wmem,
                pq[2].rd, pq[2].wreg, pq[2].reg2reg};
    endfunction

    task automatic model_reset();
        rec_t r = '{op: 6'd0, rd: 5'd0, wreg: 1'b0, reg2reg: 1'b0, wmem: 1'b0, valid: 1'b0};
        pq = '{r, r, r};
        m_stall = 0; m_flush = 0; m_retire = 0;
        s_stall = 0; s_flush = 0; s_retire = 0;
    endtask

    task automatic do_reset();
        Clrn = 1'b0;
        #1;
        Clrn = 1'b1;
        model_reset();
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                          input logic regrt, input logic wreg, input logic r2r, input logic wmem);
        Op = op; Rt = rt; Rd = rd; Regrt = regrt; Wreg = wreg; Reg2reg = r2r; Wmem = wmem;
    endtask

    // One clock edge; model advances alongside, then outputs settle before checks.
    task automatic tick();
        rec_t nr;
        bit   st, fl, rt;
        if (!STALL || !Condep)
            nr = '{op: 6'd0, rd: 5'd0, wreg: 1'b0, reg2reg: 1'b1, wmem: 1'b0, valid: 1'b0};
        else
            nr = '{op: Op, rd: (Regrt ? Rt : Rd), wreg: Wreg, reg2reg: Reg2reg, wmem: Wmem, valid: 1'b1};
        st = !STALL && Condep;
        fl = !Condep;
        rt = pq[2].valid;
        @(posedge Clk);
        pq.push_front(nr);
        void'(pq.pop_back());
        if (st) begin m_stall = sat(m_stall, 65535); s_stall = sat(s_stall, 15); end
        if (fl) begin m_flush = sat(m_flush, 65535); s_flush = sat(s_flush, 15); end
        if (rt) begin m_retire = sat(m_retire, 65535); s_retire = sat(s_retire, 15); end
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (act !== 29'd0 || s_act !== 29'd0) begin
            n_fail++; $display("FAIL reset_initial: got %h/%h want 0", act, s_act);
        end
        do_reset();
        set_id(6'b101011, 5'd9, 5'd12, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        n_checks++;
        if (act !== exp_vec()) begin
            n_fail++; $display("FAIL reset_prefill: got %h want %h", act, exp_vec());
        end
        #2;
        Clrn = 1'b0;
        #1;
        n_checks++;
        if (act !== 29'd0 || eOp !== 6'd0 || retire_cnt !== 16'd0 || s_act !== 29'd0) begin
            n_fail++; $display("FAIL reset_async: got %h eOp %0d ret %0d want 0", act, eOp, retire_cnt);
        end
        Clrn = 1'b1;
        model_reset();
        set_id(6'b001000, 5'd14, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (eRd !== 5'd14 || eWreg !== 1'b1 || eOp !== 6'b001000) begin
            n_fail++; $display("FAIL reset_first_instr: got rd %0d wreg %0b op %0d want 14 1 8", eRd, eWreg, eOp);
        end
    endtask

    task automatic test_straight_flow();
        do_reset();
        STALL = 1'b1; Condep = 1'b1;
        set_id(6'b000000, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (eRd !== 5'd5 || eWreg !== 1'b1) begin
            n_fail++; $display("FAIL flow_e_add: got rd %0d wreg %0b want 5 1", eRd, eWreg);
        end
        set_id(6'b001000, 5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (mRd !== 5'd5 || eRd !== 5'd7) begin
            n_fail++; $display("FAIL flow_m_add: got mRd %0d eRd %0d want 5 7", mRd, eRd);
        end
        set_id(6'b000000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (wRd !== 5'd5 || wWreg !== 1'b1 || mRd !== 5'd7) begin
            n_fail++; $display("FAIL flow_w_add: got wRd %0d wWreg %0b mRd %0d want 5 1 7", wRd, wWreg, mRd);
        end
        tick();
        n_checks++;
        if (wRd !== 5'd7) begin
            n_fail++; $display("FAIL flow_w_addi: got %0d want 7", wRd);
        end
        tick();
        n_checks++;
        if (retire_cnt !== 16'd2) begin
            n_fail++; $display("FAIL flow_retire: got %0d want 2", retire_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(6'b100011, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        STALL = 1'b0; Condep = 1'b1;
        tick();
        n_checks++;
        if (eWreg !== 1'b0 || eRd !== 5'd0 || stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
            n_fail++; $display("FAIL load_use_bubble: got wreg %0b rd %0d stall %0d flush %0d want 0 0 1 0",
                               eWreg, eRd, stall_cnt, flush_cnt);
        end
        STALL = 1'b1;
        tick();
        n_checks++;
        if (mWreg !== 1'b0 || eRd !== 5'd3 || eWreg !== 1'b1 || eReg2reg !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release: got mWreg %0b eRd %0d eWreg %0b want 0 3 1", mWreg, eRd, eWreg);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(6'b000100, 5'd4, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1);
        STALL = 1'b1; Condep = 1'b0;
        tick();
        n_checks++;
        if (eWreg !== 1'b0 || eOp !== 6'd0 || eWmem !== 1'b0 || eReg2reg !== 1'b1 || flush_cnt !== 16'd1) begin
            n_fail++; $display("FAIL flush_bubble: got wreg %0b op %0d wmem %0b r2r %0b flush %0d want 0 0 0 1 1",
                               eWreg, eOp, eWmem, eReg2reg, flush_cnt);
        end
        Condep = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (retire_cnt !== 16'd0) begin
            n_fail++; $display("FAIL flush_not_retired: got %0d want 0", retire_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_id(6'b000000, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        STALL = 1'b0; Condep = 1'b0;
        tick();
        n_checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0 || eWreg !== 1'b0) begin
            n_fail++; $display("FAIL simul_counts: got flush %0d stall %0d wreg %0b want 1 0 0",
                               flush_cnt, stall_cnt, eWreg);
        end
        STALL = 1'b1; Condep = 1'b1;
        tick();
        n_checks++;
        if (eWreg !== 1'b1 || eRd !== 5'd9 || mWreg !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL simul_one_bubble: got eWreg %0b eRd %0d mWreg %0b want 1 9 0", eWreg, eRd, mWreg);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        STALL = 1'b0; Condep = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
            n_fail++; $display("FAIL saturation: got small %0d wide %0d want 15 20", s_stall_cnt, stall_cnt);
        end
        STALL = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id(6'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            STALL  = ($urandom_range(0, 3) != 0);
            Condep = ($urandom_range(0, 4) != 0);
            tick();
            n_checks++;
            if (act !== exp_vec() || s_act !== exp_vec()) begin
                n_fail++; $display("FAIL rand_stages[%0d]: got %h/%h want %h", i, act, s_act, exp_vec());
            end
            n_checks++;
            if (int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush || int'(retire_cnt) != m_retire ||
                int'(s_stall_cnt) != s_stall || int'(s_flush_cnt) != s_flush || int'(s_retire_cnt) != s_retire) begin
                n_fail++; $display("FAIL rand_counters[%0d]: got %0d/%0d/%0d s %0d/%0d/%0d want %0d/%0d/%0d s %0d/%0d/%0d",
                                   i, stall_cnt, flush_cnt, retire_cnt, s_stall_cnt, s_flush_cnt, s_retire_cnt,
                                   m_stall, m_flush, m_retire, s_stall, s_flush, s_retire);
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_straight_flow();
        test_load_use();
        test_flush();
        test_simultaneous();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_tracker.md
Name: pipe_hazard_tracker

Overview:
- Control-side pipeline register chain (ID/EX, EX/MEM, MEM/WB) that drives the execute/memory-stage hazard inputs of the decode control unit: eRd, eWreg, eReg2reg, eOp, mRd, mWreg.
- Consumes the control unit's STALL and Condep outputs and inserts bubbles into ID/EX.
- Keeps saturating stall, flush and retire counters for performance debug.
- Sits beside the datapath pipeline registers in the five-stage core.

Parameters:
- CNT_W, 16, width of each performance counter.
- NOP_OP, 6'b000000, opcode loaded into eOp for a bubble (never a branch or jump opcode).

Ports:
- Clk  input  1  core clock, rising edge.
- Clrn  input  1  asynchronous active-low reset.
- Op  input  6  ID-stage opcode.
- Rt  input  5  ID-stage rt field.
- Rd  input  5  ID-stage rd field.
- Regrt  input  1  1 = destination is Rt, 0 = destination is Rd.
- Wreg  input  1  ID-stage register-write enable.
- Reg2reg  input  1  ID-stage writeback source (0 = memory load).
- Wmem  input  1  ID-stage memory-write enable.
- STALL  input  1  from the control unit; 0 = load-use stall.
- Condep  input  1  from the control unit; 0 = taken branch/jump in EX, flush ID.
- eOp  output  6  EX-stage opcode.
- eRd  output  5  EX-stage destination register.
- eWreg  output  1  EX-stage register-write enable.
- eReg2reg  output  1  EX-stage writeback source.
- eWmem  output  1  EX-stage memory write.
- mRd  output  5  MEM-stage destination.
- mWreg  output  1  MEM-stage register-write enable.
- mReg2reg  output  1  MEM-stage writeback source.
- mWmem  output  1  MEM-stage memory write.
- wRd  output  5  WB-stage destination.
- wWreg  output  1  WB-stage register-write enable.
- wReg2reg  output  1  WB-stage writeback source.
- stall_cnt  output  CNT_W  cycles with STALL=0 and Condep=1.
- flush_cnt  output  CNT_W  cycles with Condep=0.
- retire_cnt  output  CNT_W  valid instructions leaving WB.

Behaviour:
- Reset (Clrn=0, asynchronous, no clock needed):
  - All outputs 0, eOp=NOP_OP.
  - Per-stage valid bits eV, mV, wV = 0.
  - Counters = 0.
- Destination: dRd = Regrt ? Rt : Rd, computed combinationally in ID.
- ID/EX update, every rising edge:
  - Bubble when STALL=0 or Condep=0. The stage loads eOp=NOP_OP, eRd=0, eWreg=0, eWmem=0, eReg2reg=1, eV=0.
  - Otherwise it loads Op, dRd, Wreg, Reg2reg, Wmem, with eV=1.
- EX/MEM and MEM/WB advance unconditionally every cycle, copying the previous stage's fields and valid bit. A bubble propagates as a bubble.
- Latency: an ID instruction appears on e* 1 edge later, on m* 2 edges later, and on w* 3 edges later.
- Stall and flush in the same cycle: one bubble is inserted. Only flush_cnt increments.
- Stall semantics: the block inserts the bubble only. Holding the PC and IF/ID is done by their own registers, which use the same STALL.
- Counters:
  - stall_cnt += 1 when STALL=0 and Condep=1.
  - flush_cnt += 1 when Condep=0.
  - retire_cnt += 1 on each edge where wV=1, meaning the instruction leaves WB on that edge.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation clears all stages immediately. The first instruction after Clrn rises enters ID/EX on the next edge.
- Write to r0: the block passes Wreg through unchanged. The control unit's rd!=0 check already suppresses forwarding and stalls for r0.
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - NOP_OP.
  - Opcode constants OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_J=6'b000010.
  - Register-index width 5.
  - A stage-record typedef {op, rd, wreg, reg2reg, wmem, valid}.
- One sub-module, sat_counter, instantiated three times with params CNT_W, inc, Clk, Clrn.
- Stage registers are written inline.

Test Plan:
- Reset: assert Clrn=0 mid-clock with non-zero stages. All outputs are 0 and eOp=0 immediately, before any clock edge.
- Straight flow: issue add with Rd=5, Wreg=1, Reg2reg=1, then addi with Regrt=1, Rt=7.
  - The add gives eRd=5 at edge 1, mRd=5 at edge 2, wRd=5 at edge 3.
  - The addi follows one cycle behind with rd=7.
  - retire_cnt=2 after edge 5.
- Load-use: hold STALL=0 for one cycle with lw (Op=6'b100011, Rt=3) in ID. ID/EX becomes a bubble (eWreg=0, eRd=0), stall_cnt=1, and the bubble reaches mWreg=0 next cycle.
- Flush: Condep=0 with Wreg=1 in ID. eV=0, eWreg=0, eOp=0, flush_cnt=1.
- Simultaneous: STALL=0 and Condep=0 together. Exactly one bubble is inserted, flush_cnt increments and stall_cnt is unchanged.
- Saturation: CNT_W=4 with STALL=0 held for 20 cycles. stall_cnt sticks at 15.
